// File: rtl/lock_button_conditioner.sv
// lock_button_conditioner
//   Front end for the digital lock FSM. Two raw, asynchronous, bouncing
//   push-buttons are synchronised, debounced and arbitrated into clean
//   single-cycle press pulses b0/b1. Overlapping presses are rejected.
//   Optional feature: define KEY_TIMEOUT_EN to build the idle timeout that
//   pulses idle_clr after TIMEOUT_CYCLES idle clocks following a press.
//   Without the macro idle_clr is tied low and no timeout logic exists.
module lock_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn0_raw,
  input  logic btn1_raw,
  output logic b0,
  output logic b1,
  output logic busy,
  output logic idle_clr
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject parameter values the counters cannot represent.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("lock_button_conditioner: DEBOUNCE_CYCLES must be >= 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("lock_button_conditioner: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HELD0   = 2'd1,
    HELD1   = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  // Channel 0 is button 0, channel 1 is button 1.
  logic [1:0]       raw;
  logic [1:0]       s1;
  logic [1:0]       s2;
  logic [1:0]       db;
  logic [CNT_W-1:0] db_cnt [2];

  state_t state;
  logic   press0_c;
  logic   press1_c;

  assign raw = {btn1_raw, btn0_raw};

  // Two-flop synchroniser; the only logic that touches the raw inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Debounce: a changed level must persist DEBOUNCE_CYCLES clocks to be accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      db <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // A lone debounced press seen while idle is the only source of a pulse.
  assign press0_c = (state == IDLE) && db[0] && !db[1];
  assign press1_c = (state == IDLE) && db[1] && !db[0];

  // Arbiter: one pulse per accepted press, any overlap forces a lockout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      b0    <= 1'b0;
      b1    <= 1'b0;
      busy  <= 1'b0;
    end else begin
      b0 <= 1'b0;
      b1 <= 1'b0;
      case (state)
        IDLE: begin
          if (db[0] && db[1]) begin
            state <= LOCKOUT;
            busy  <= 1'b1;
          end else if (press0_c) begin
            state <= HELD0;
            b0    <= 1'b1;
            busy  <= 1'b1;
          end else if (press1_c) begin
            state <= HELD1;
            b1    <= 1'b1;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        // A second button joining the held one is an overlap, even if the
        // first is released on the same clock.
        HELD0: begin
          if (db[1]) begin
            state <= LOCKOUT;
            busy  <= 1'b1;
          end else if (!db[0]) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        HELD1: begin
          if (db[0]) begin
            state <= LOCKOUT;
            busy  <= 1'b1;
          end else if (!db[1]) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        LOCKOUT: begin
          if (!db[0] && !db[1]) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef KEY_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [IDLE_W-1:0] idle_cnt;
  logic              idle_armed;

  // Idle timeout: armed by each pulse; a pulse on the expiry clock re-arms instead.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt   <= '0;
      idle_armed <= 1'b0;
      idle_clr   <= 1'b0;
    end else begin
      idle_clr <= 1'b0;
      if (press0_c || press1_c) begin
        idle_cnt   <= '0;
        idle_armed <= 1'b1;
      end else if (idle_armed) begin
        if (idle_cnt == IDLE_LAST) begin
          idle_clr   <= 1'b1;
          idle_armed <= 1'b0;
          idle_cnt   <= '0;
        end else begin
          idle_cnt <= idle_cnt + IDLE_W'(1);
        end
      end
    end
  end
`else
  assign idle_clr = 1'b0;
`endif

endmodule
